// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit:
// op encodings, FSM states and default busy-cycle counts.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MDU_OP_MULT  = 3'd0,
    MDU_OP_MULTU = 3'd1,
    MDU_OP_DIV   = 3'd2,
    MDU_OP_DIVU  = 3'd3,
    MDU_OP_MTHI  = 3'd4,
    MDU_OP_MTLO  = 3'd5,
    MDU_OP_MADD  = 3'd6,
    MDU_OP_MADDU = 3'd7
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  function automatic logic is_div(mdu_op_e op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multicycle HI/LO multiply/divide unit for the EX stage.
// Ports: clk, reset (async, active-low), start/op/d1/d2 request,
//   flush cancel, busy status, hi/lo architectural registers.
// Optional: define MULT_DIV_UNIT_MADD_EN to enable madd/maddu.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int W2 = 2 * WIDTH;

  mdu_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  mdu_op_e          op_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  mdu_op_e op_e;
  assign op_e = mdu_op_e'(op);

  // Launch decode for a start seen in IDLE
  logic          launch;
  logic [CW-1:0] cnt_init;

  always_comb begin
    launch   = 1'b0;
    cnt_init = '0;
    case (op_e)
      MDU_OP_MULT, MDU_OP_MULTU: begin
        launch   = 1'b1;
        cnt_init = CW'(MULT_CYCLES);
      end
      MDU_OP_DIV, MDU_OP_DIVU: begin
        launch   = 1'b1;
        cnt_init = CW'(DIV_CYCLES);
      end
`ifdef MULT_DIV_UNIT_MADD_EN
      MDU_OP_MADD, MDU_OP_MADDU: begin
        launch   = 1'b1;
        cnt_init = CW'(MULT_CYCLES);
      end
`endif
      default: begin
        launch   = 1'b0;
        cnt_init = '0;
      end
    endcase
  end

  // Arithmetic on latched operands only
  logic [W2-1:0]    a_sx, b_sx, a_zx, b_zx;
  logic [W2-1:0]    prod_s, prod_u;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] q_s, r_s, q_u, r_u;
  logic             ovf;
  logic [W2-1:0]    res;
  logic             wr_en;

  assign a_sx   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign b_sx   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign a_zx   = {{WIDTH{1'b0}}, a_q};
  assign b_zx   = {{WIDTH{1'b0}}, b_q};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // Divisor forced non-zero; a zero divide never writes anyway
  assign dvsr = (b_q == '0) ? WIDTH'(1) : b_q;
  // Most-negative / -1 overflows; pin the result explicitly
  assign ovf  = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) &&
                (b_q == {WIDTH{1'b1}});
  assign q_s  = ovf ? a_q : WIDTH'($signed(a_q) / $signed(dvsr));
  assign r_s  = ovf ? '0  : WIDTH'($signed(a_q) % $signed(dvsr));
  assign q_u  = a_q / dvsr;
  assign r_u  = a_q % dvsr;

  always_comb begin
    res   = {hi_q, lo_q};
    wr_en = 1'b1;
    case (op_q)
      MDU_OP_MULT:  res = prod_s;
      MDU_OP_MULTU: res = prod_u;
      MDU_OP_DIV:   res = {r_s, q_s};
      MDU_OP_DIVU:  res = {r_u, q_u};
`ifdef MULT_DIV_UNIT_MADD_EN
      MDU_OP_MADD:  res = {hi_q, lo_q} + prod_s;
      MDU_OP_MADDU: res = {hi_q, lo_q} + prod_u;
`endif
      default:      wr_en = 1'b0;
    endcase
    if (is_div(op_q) && (b_q == '0)) wr_en = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= MDU_OP_MULT;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !flush) begin
            if (launch) begin
              a_q     <= d1;
              b_q     <= d2;
              op_q    <= op_e;
              cnt_q   <= cnt_init;
              state_q <= RUN;
            end else if (op_e == MDU_OP_MTHI) begin
              hi_q <= d1;
            end else if (op_e == MDU_OP_MTLO) begin
              lo_q <= d1;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CW'(1);
          if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(1)) begin
            state_q <= IDLE;
            if (wr_en) {hi_q, lo_q} <= res;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit:
// vector table plus hand sequences for flush/reset/back-to-back.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] d1, d2;
  logic        flush;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .d1    (d1),
    .d2    (d2),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] phi;
    logic [31:0] plo;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          ecyc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(string n, logic [2:0] o, logic [31:0] a,
                     logic [31:0] b, logic [31:0] ph,
                     logic [31:0] pl, logic [31:0] eh,
                     logic [31:0] el, int c);
    vec_t v;
    v.name = n; v.op = o; v.d1 = a; v.d2 = b;
    v.phi = ph; v.plo = pl; v.ehi = eh; v.elo = el;
    v.ecyc = c;
    vecs.push_back(v);
  endtask

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic issue(logic [2:0] o, logic [31:0] a,
                       logic [31:0] b);
    op = o; d1 = a; d2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic preset(logic [31:0] h, logic [31:0] l);
    issue(3'd4, h, 32'h0);
    issue(3'd5, l, 32'h0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; op = '0;
    d1 = '0; d2 = '0; flush = 1'b0;

    add("mult",     3'd0, 32'hFFFFFFFE, 32'd3, 0, 0,
        32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    add("multu",    3'd1, 32'hFFFFFFFE, 32'd3, 0, 0,
        32'h00000002, 32'hFFFFFFFA, 5);
    add("div",      3'd2, 32'hFFFFFFF9, 32'd2, 0, 0,
        32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    add("divu0",    3'd3, 32'd7, 32'd0, 32'h11, 32'h22,
        32'h11, 32'h22, 10);
    add("divovf",   3'd2, 32'h80000000, 32'hFFFFFFFF, 5, 6,
        32'h0, 32'h80000000, 10);
    add("divu",     3'd3, 32'd100, 32'd7, 0, 0,
        32'd2, 32'd14, 10);
    add("divnegd",  3'd2, 32'd7, 32'hFFFFFFFE, 0, 0,
        32'd1, 32'hFFFFFFFD, 10);
    add("multmin",  3'd0, 32'h80000000, 32'h80000000, 0, 0,
        32'h40000000, 32'h0, 5);
    add("multumax", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0,
        32'hFFFFFFFE, 32'h00000001, 5);
`ifdef MULT_DIV_UNIT_MADD_EN
    add("madd",     3'd6, 32'hFFFFFFFF, 32'd1, 0, 5,
        32'h0, 32'h4, 5);
    add("maddu",    3'd7, 32'hFFFFFFFF, 32'd2, 1, 32'hFFFFFFFF,
        32'h3, 32'hFFFFFFFD, 5);
`else
    add("madd",     3'd6, 32'hFFFFFFFF, 32'd1, 0, 5,
        32'h0, 32'h5, 0);
    add("maddu",    3'd7, 32'hFFFFFFFF, 32'd2, 1, 32'hFFFFFFFF,
        32'h1, 32'hFFFFFFFF, 0);
`endif

    #12;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      preset(vecs[i].phi, vecs[i].plo);
      issue(vecs[i].op, vecs[i].d1, vecs[i].d2);
      wait_idle(n);
      chk({vecs[i].name, "_cyc"}, n, vecs[i].ecyc);
      chk({vecs[i].name, "_hi"}, hi, vecs[i].ehi);
      chk({vecs[i].name, "_lo"}, lo, vecs[i].elo);
    end

    // mthi then mtlo on consecutive edges
    issue(3'd4, 32'hABCD0000, 32'h0);
    chk("mthi_hi", hi, 32'hABCD0000);
    chk("mthi_busy", {31'b0, busy}, 32'h0);
    issue(3'd5, 32'h00001234, 32'h0);
    chk("mtlo_lo", lo, 32'h00001234);
    chk("mtlo_busy", {31'b0, busy}, 32'h0);
    flush = 1'b1;
    issue(3'd4, 32'h0000FFFF, 32'h0);
    flush = 1'b0;
    chk("mthi_flush", hi, 32'hABCD0000);

    // Flush in busy cycle 4, mid-run mult start in cycle 2
    preset(32'h55, 32'h66);
    issue(3'd2, 32'd100, 32'd3);
    @(negedge clk);
    op = 3'd0; d1 = 32'd5; d2 = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'h0);
    chk("flush_hi", hi, 32'h55);
    chk("flush_lo", lo, 32'h66);
    repeat (12) @(negedge clk);
    chk("flush_late_busy", {31'b0, busy}, 32'h0);
    chk("flush_late_hi", hi, 32'h55);
    chk("flush_late_lo", lo, 32'h66);

    // Flush on the completing edge
    preset(32'h77, 32'h88);
    issue(3'd0, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    chk("last_busy_pre", {31'b0, busy}, 32'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("lastflush_busy", {31'b0, busy}, 32'h0);
    chk("lastflush_hi", hi, 32'h77);
    chk("lastflush_lo", lo, 32'h88);

    // Back-to-back starts
    issue(3'd0, 32'd2, 32'd3);
    wait_idle(n);
    chk("b2b1_lo", lo, 32'd6);
    issue(3'd1, 32'd4, 32'd5);
    chk("b2b2_busy", {31'b0, busy}, 32'h1);
    wait_idle(n);
    chk("b2b2_cyc", n, 32'd5);
    chk("b2b2_hi", hi, 32'd0);
    chk("b2b2_lo", lo, 32'd20);

    // Asynchronous reset mid-run
    preset(32'h99, 32'hAA);
    issue(3'd2, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'h0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("arst_after_busy", {31'b0, busy}, 32'h0);
    chk("arst_after_lo", lo, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
